fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the pipelined core. It replaces the free-running PC counter and combinational instruction ROM of the single-cycle datapath. It owns the PC register and issues requests to a 1-cycle-latency synchronous instruction memory. It buffers returned instructions with their PC in a small prefetch FIFO and hands them to decode over a valid/ready handshake, with a redirect/flush path for taken branches and jumps.

---
 rtl/core_pkg.sv | 8 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Core-wide parameters shared by the fetch, decode and execute stages.
package core_pkg;

  localparam int unsigned DWidth  = 32;
  localparam logic [31:0] ResetPc = 32'h0;
  localparam int unsigned PcInc   = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with a synchronous flush and an occupancy output.
// Each entry holds one {pc, instr} pair.
module fetch_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push_i, pop_i})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues to a 1-cycle-latency instruction memory and
// queues returned {pc, instr} pairs for decode, with a redirect path that flushes everything.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned        D_WIDTH    = DWidth,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter logic [D_WIDTH-1:0] RESET_PC   = D_WIDTH'(ResetPc),
  parameter int unsigned        PC_INC     = PcInc
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [D_WIDTH-1:0]          imem_addr,
  input  logic [D_WIDTH-1:0]          imem_rdata,
  input  logic                        redirect_valid,
  input  logic [D_WIDTH-1:0]          redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [D_WIDTH-1:0]          out_instr,
  output logic [D_WIDTH-1:0]          out_pc,
  output logic [$clog2(FIFO_DEPTH):0] out_level
);

  logic [D_WIDTH-1:0]   pc_q, pc_d;
  logic [D_WIDTH-1:0]   tag_q, tag_d;
  logic                 inflight_q, inflight_d;
  logic                 issue, push, pop, credit_ok;
  logic [2*D_WIDTH-1:0] head;

  assign pop = out_valid && out_ready;

  // Outstanding = queued entries + the response landing now - what decode drains this cycle.
  assign credit_ok = (32'(out_level) + 32'(inflight_q)) < (FIFO_DEPTH + 32'(pop));
  assign issue     = rst && !redirect_valid && credit_ok;

  // The response lands exactly one cycle after issue, so a redirect in that cycle kills it.
  assign push = inflight_q && !redirect_valid;

  assign out_valid = (out_level != '0) && !redirect_valid;
  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign {out_pc, out_instr} = head;

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d  = pc_q + D_WIDTH'(PC_INC);
      tag_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .Width(2 * D_WIDTH),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush_i(redirect_valid),
    .push_i (push),
    .wdata_i({tag_q, imem_rdata}),
    .pop_i  (pop),
    .rdata_o(head),
    .level_o(out_level)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a queue-based model.
module tb_fetch_unit;

  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  out_level;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .D_WIDTH   (32),
    .FIFO_DEPTH(Depth),
    .RESET_PC  (32'h0),
    .PC_INC    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_level     (out_level)
  );

  always #5 clk = ~clk;

  // ROM: word[i] = i, returned one cycle after the request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr >> 2;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
  endtask

  // Leaves the bench inside cycle 0 (before the first rising edge after release).
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = rdy;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req);
    if (imem_req !== 1'b0) n_fail++;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", out_level); end
    n_checks++;
    if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    n_checks++;
    if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", out_instr); end
  endtask

  task automatic test_startup;
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step(1'b0, 32'h0, 1'b1);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL startup_req c%0d: got req=%b addr=%h want req=1 addr=%h",
                 k, imem_req, imem_addr, 32'(4 * k));
      end
      n_checks++;
      if (out_valid !== (k >= 2)) begin
        n_fail++;
        $display("FAIL startup_valid c%0d: got %b want %b", k, out_valid, (k >= 2));
      end
      if (k >= 2) begin
        n_checks++;
        if (out_pc !== 32'(4 * (k - 2)) || out_instr !== 32'(k - 2) || out_level !== 3'd1) begin
          n_fail++;
          $display("FAIL startup_head c%0d: got pc=%h instr=%h lvl=%0d want pc=%h instr=%h lvl=1",
                   k, out_pc, out_instr, out_level, 32'(4 * (k - 2)), 32'(k - 2));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int reqs = 0;
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step(1'b0, 32'h0, 1'b0);
      if (imem_req === 1'b1) begin
        n_checks++;
        if (imem_addr !== 32'(4 * reqs)) begin
          n_fail++;
          $display("FAIL bp_addr c%0d: got %h want %h", k, imem_addr, 32'(4 * reqs));
        end
        reqs++;
      end
      if (k >= 4) begin
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_stall c%0d: got req=%b want 0", k, imem_req); end
      end
    end
    n_checks++;
    if (reqs != Depth) begin n_fail++; $display("FAIL bp_count: got %0d requests want %0d", reqs, Depth); end
    n_checks++;
    if (out_level !== 3'(Depth)) begin n_fail++; $display("FAIL bp_level: got %0d want %0d", out_level, Depth); end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 32'h0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'(k)) begin
        n_fail++;
        $display("FAIL bp_drain %0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 k, out_valid, out_pc, out_instr, 32'(4 * k), 32'(k));
      end
    end
  endtask

  task automatic test_flush;
    do_reset(1'b0);
    for (int k = 1; k < 4; k++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h100, 1'b1);
    n_checks++;
    if (out_level !== 3'd3 || out_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_t: got lvl=%0d v=%b req=%b want lvl=3 v=0 req=0",
               out_level, out_valid, imem_req);
    end
    step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100 || out_level !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_t1: got v=%b req=%b addr=%h lvl=%0d want v=0 req=1 addr=100 lvl=0",
               out_valid, imem_req, imem_addr, out_level);
    end
    step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_t2: got v=%b want 0", out_valid); end
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 32'h0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * j) || out_instr !== 32'h40 + 32'(j)) begin
        n_fail++;
        $display("FAIL flush_stream %0d: got v=%b pc=%h instr=%h want v=1 pc=%h",
                 j, out_valid, out_pc, out_instr, 32'h100 + 32'(4 * j));
      end
    end
  endtask

  task automatic test_collision;
    bit seen = 1'b0;
    do_reset(1'b1);
    for (int k = 1; k < 4; k++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h200, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL coll_nopop: got v=%b want 0", out_valid); end
    for (int k = 0; k < 6 && !seen; k++) begin
      step(1'b0, 32'h0, 1'b1);
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        n_checks++;
        if (out_pc !== 32'h200 || k != 2) begin
          n_fail++;
          $display("FAIL coll_target: got pc=%h at t+%0d want pc=200 at t+3", out_pc, k + 1);
        end
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL coll_timeout: got no valid entry want pc=200"); end
  endtask

  task automatic test_midreset;
    do_reset(1'b0);
    for (int k = 1; k < 7; k++) step(1'b0, 32'h0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_level !== 3'd4) begin
      n_fail++;
      $display("FAIL mrst_pre: got v=%b lvl=%0d want v=1 lvl=4", out_valid, out_level);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_level !== 3'd0 || imem_req !== 1'b0 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL mrst_drop: got v=%b lvl=%0d req=%b pc=%h want 0 0 0 0",
               out_valid, out_level, imem_req, out_pc);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL mrst_restart: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL mrst_first: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap_double;
    logic [31:0] wrap_pcs [3];
    wrap_pcs[0] = 32'hFFFF_FFF8;
    wrap_pcs[1] = 32'hFFFF_FFFC;
    wrap_pcs[2] = 32'h0;
    do_reset(1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 32'h0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== wrap_pcs[j] || out_instr !== (wrap_pcs[j] >> 2)) begin
        n_fail++;
        $display("FAIL wrap %0d: got v=%b pc=%h instr=%h want v=1 pc=%h",
                 j, out_valid, out_pc, out_instr, wrap_pcs[j]);
      end
    end
    step(1'b1, 32'h40, 1'b1);
    n_checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dbl_t: got req=%b v=%b want 0 0", imem_req, out_valid);
    end
    step(1'b1, 32'h80, 1'b1);
    n_checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dbl_t1: got req=%b v=%b want 0 0", imem_req, out_valid);
    end
    step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dbl_issue: got req=%b addr=%h v=%b want req=1 addr=80 v=0",
               imem_req, imem_addr, out_valid);
    end
    step(1'b0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dbl_gap: got v=%b want 0", out_valid); end
    for (int j = 0; j < 2; j++) begin
      step(1'b0, 32'h0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h80 + 32'(4 * j)) begin
        n_fail++;
        $display("FAIL dbl_stream %0d: got v=%b pc=%h want v=1 pc=%h",
                 j, out_valid, out_pc, 32'h80 + 32'(4 * j));
      end
    end
  endtask

  // Model: every issued PC is queued with its issue cycle; it becomes visible to decode two
  // cycles later, leaves in order on a handshake, and the whole queue dies on a redirect.
  task automatic test_random;
    logic [31:0] pcq [$];
    int          stq [$];
    logic [31:0] next_pc = 32'h0;
    logic        rv, rdy, exp_valid, exp_pop, exp_req;
    logic [31:0] rpc;
    int          visible;
    do_reset(1'b1);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom & 32'hFFFF_FFFC;
      rdy = ($urandom_range(0, 3) != 0);
      if (cyc > 0) begin
        step(rv, rpc, rdy);
      end else begin
        redirect_valid = rv;
        redirect_pc = rpc;
        out_ready = rdy;
        #1;
      end
      visible = 0;
      foreach (stq[i]) if (stq[i] <= cyc - 2) visible++;
      exp_valid = !rv && (visible > 0);
      exp_pop   = exp_valid && rdy;
      exp_req   = !rv && ((pcq.size() - int'(exp_pop)) < Depth);
      n_checks++;
      if (out_valid !== exp_valid || out_level !== 3'(visible)) begin
        n_fail++;
        $display("FAIL rnd_valid c%0d: got v=%b lvl=%0d want v=%b lvl=%0d",
                 cyc, out_valid, out_level, exp_valid, visible);
      end
      n_checks++;
      if (imem_req !== exp_req || (exp_req && imem_addr !== next_pc)) begin
        n_fail++;
        $display("FAIL rnd_req c%0d: got req=%b addr=%h want req=%b addr=%h",
                 cyc, imem_req, imem_addr, exp_req, next_pc);
      end
      if (exp_valid) begin
        n_checks++;
        if (out_pc !== pcq[0] || out_instr !== (pcq[0] >> 2)) begin
          n_fail++;
          $display("FAIL rnd_head c%0d: got pc=%h instr=%h want pc=%h instr=%h",
                   cyc, out_pc, out_instr, pcq[0], pcq[0] >> 2);
        end
      end
      if (rv) begin
        pcq.delete();
        stq.delete();
        next_pc = rpc;
      end else begin
        if (exp_pop) begin
          void'(pcq.pop_front());
          void'(stq.pop_front());
        end
        if (exp_req) begin
          pcq.push_back(next_pc);
          stq.push_back(cyc);
          next_pc = next_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_flush();
    test_collision();
    test_midreset();
    test_wrap_double();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
